// File: rtl/aes_sbox_sched.sv
// Arbiter and sequencer sharing one 4-lane combinational AES S-box between the
// key-memory word path (one pass) and the encipher block path (four passes).
module aes_sbox_sched #(
  parameter int KM_PRIORITY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         km_req,
  input  logic [31:0]  km_word,
  output logic         km_ack,
  output logic [31:0]  km_result,
  input  logic         enc_req,
  input  logic [127:0] enc_block,
  output logic         enc_ack,
  output logic [127:0] enc_result,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KM_SUB, ENC_SUB} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    idx_reg, idx_next;
  logic          last_km_reg;
  logic          km_ack_reg, enc_ack_reg;
  logic [31:0]   km_word_reg, km_result_reg;
  logic [127:0]  block_reg;
  logic [31:0]   block_word [4];
  logic          km_elig, enc_elig, pick_km;
  logic          grant_km, grant_enc;

  // Word 0 is the most significant 32 bits of the block.
  for (genvar gi = 0; gi < 4; gi++) begin : g_words
    logic [31:0] res_word_reg;

    assign block_word[gi] = block_reg[127-32*gi -: 32];
    assign enc_result[127-32*gi -: 32] = res_word_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        res_word_reg <= 32'h0;
      end else if (state_reg == ENC_SUB && idx_reg == 2'(gi)) begin
        res_word_reg <= new_sboxw;
      end
    end
  end

  // A requester is not eligible in the cycle its own ack is showing.
  assign km_elig  = km_req & ~km_ack_reg;
  assign enc_elig = enc_req & ~enc_ack_reg;
  assign pick_km  = (KM_PRIORITY != 0) || !last_km_reg;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    grant_km   = 1'b0;
    grant_enc  = 1'b0;
    sboxw      = 32'h0;
    case (state_reg)
      IDLE: begin
        grant_km  = km_elig & (~enc_elig | pick_km);
        grant_enc = enc_elig & ~grant_km;
        if (grant_km) begin
          state_next = KM_SUB;
        end else if (grant_enc) begin
          state_next = ENC_SUB;
          idx_next   = 2'd0;
        end
      end
      KM_SUB: begin
        sboxw      = km_word_reg;
        state_next = IDLE;
      end
      ENC_SUB: begin
        sboxw    = block_word[idx_reg];
        idx_next = idx_reg + 2'd1;
        if (idx_reg == 2'd3) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      idx_reg       <= 2'd0;
      last_km_reg   <= 1'b0;
      km_ack_reg    <= 1'b0;
      enc_ack_reg   <= 1'b0;
      km_word_reg   <= 32'h0;
      km_result_reg <= 32'h0;
      block_reg     <= 128'h0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      km_ack_reg  <= (state_reg == KM_SUB);
      enc_ack_reg <= (state_reg == ENC_SUB) && (idx_reg == 2'd3);
      if (grant_km) begin
        km_word_reg <= km_word;
        last_km_reg <= 1'b1;
      end
      if (grant_enc) begin
        block_reg   <= enc_block;
        last_km_reg <= 1'b0;
      end
      if (state_reg == KM_SUB) begin
        km_result_reg <= new_sboxw;
      end
    end
  end

  assign km_ack    = km_ack_reg;
  assign enc_ack   = enc_ack_reg;
  assign km_result = km_result_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_aes_sbox_sched.sv
// Self-checking bench: a round-robin and a KM-priority instance share stimulus and
// are compared each cycle against a cycle-budget model plus fixed FIPS-197 vectors.
module tb_aes_sbox_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                km_req, enc_req;
  logic [31:0]         km_word;
  logic [127:0]        enc_block;
  logic [1:0]          km_ack_w, enc_ack_w, busy_w;
  logic [1:0][31:0]    km_res_w, sboxw_w, new_sboxw_w;
  logic [1:0][127:0]   enc_res_w;
  logic [7:0]          sbox_tab [256];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Instance 0 is round-robin, instance 1 gives key memory priority.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign new_sboxw_w[gi] = {sbox_tab[sboxw_w[gi][31:24]], sbox_tab[sboxw_w[gi][23:16]],
                              sbox_tab[sboxw_w[gi][15:8]],  sbox_tab[sboxw_w[gi][7:0]]};
    aes_sbox_sched #(.KM_PRIORITY(gi)) dut (
      .clk(clk), .reset(reset),
      .km_req(km_req), .km_word(km_word), .km_ack(km_ack_w[gi]), .km_result(km_res_w[gi]),
      .enc_req(enc_req), .enc_block(enc_block), .enc_ack(enc_ack_w[gi]),
      .enc_result(enc_res_w[gi]), .sboxw(sboxw_w[gi]), .new_sboxw(new_sboxw_w[gi]),
      .busy(busy_w[gi])
    );
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  // Reference: an operation is a busy budget (1 cycle KM, 4 cycles ENC) whose whole
  // result is known at grant and appears together with the ack when the budget ends.
  int          m_left [2];
  int          m_cur [2];
  bit          m_last_km [2];
  bit          m_kack [2], m_eack [2];
  logic [31:0]  m_kres [2];
  logic [127:0] m_eres [2], m_data [2], m_pend [2];

  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      bit nk, ne, ke, ee, gk;
      nk = 1'b0;
      ne = 1'b0;
      if (reset) begin
        m_left[p] = 0; m_cur[p] = 0; m_last_km[p] = 1'b0;
        m_kres[p] = '0; m_eres[p] = '0; m_data[p] = '0; m_pend[p] = '0;
      end else if (m_left[p] > 0) begin
        m_left[p]--;
        if (m_left[p] == 0) begin
          if (m_cur[p] == 1) begin
            m_kres[p] = m_pend[p][31:0];
            nk = 1'b1;
            $display("[%0d] inst%0d KM  done result=%h", cyc, p, m_kres[p]);
          end else begin
            m_eres[p] = m_pend[p];
            ne = 1'b1;
            $display("[%0d] inst%0d ENC done result=%h", cyc, p, m_eres[p]);
          end
        end
      end else begin
        ke = km_req && !m_kack[p];
        ee = enc_req && !m_eack[p];
        gk = ke && (!ee || p == 1 || !m_last_km[p]);
        if (gk) begin
          m_cur[p] = 1; m_left[p] = 1; m_last_km[p] = 1'b1;
          m_data[p] = {96'h0, km_word};
          m_pend[p] = {96'h0, sub_word(km_word)};
        end else if (ee) begin
          m_cur[p] = 2; m_left[p] = 4; m_last_km[p] = 1'b0;
          m_data[p] = enc_block;
          m_pend[p] = {sub_word(enc_block[127:96]), sub_word(enc_block[95:64]),
                       sub_word(enc_block[63:32]), sub_word(enc_block[31:0])};
        end
      end
      m_kack[p] = nk;
      m_eack[p] = ne;
    end
  end

  task automatic chk(input string tag, input int p, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cycle %0d: observed=%h expected=%h", tag, p, cyc, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [127:0] sh;
    logic [31:0]  exp_w;
    for (int p = 0; p < 2; p++) begin
      exp_w = 32'h0;
      if (m_left[p] > 0) begin
        sh = m_data[p] << (32 * (4 - m_left[p]));
        exp_w = (m_cur[p] == 1) ? m_data[p][31:0] : sh[127:96];
      end
      chk("busy", p, 128'(busy_w[p]), 128'(m_left[p] > 0));
      chk("km_ack", p, 128'(km_ack_w[p]), 128'(m_kack[p]));
      chk("enc_ack", p, 128'(enc_ack_w[p]), 128'(m_eack[p]));
      chk("sboxw", p, 128'(sboxw_w[p]), 128'(exp_w));
      chk("km_result", p, 128'(km_res_w[p]), 128'(m_kres[p]));
      if (!(m_left[p] > 0 && m_cur[p] == 2))
        chk("enc_result", p, enc_res_w[p], m_eres[p]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_model();
  endtask

  initial begin
    logic [7:0]   inv;
    logic [31:0]  kw;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h0;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    reset = 1'b1; km_req = 1'b0; enc_req = 1'b0; km_word = '0; enc_block = '0;
    repeat (2) tick();
    for (int p = 0; p < 2; p++) begin
      chk("rst_busy", p, 128'(busy_w[p]), 128'(0));
      chk("rst_sboxw", p, 128'(sboxw_w[p]), 128'(0));
      chk("rst_enc_result", p, enc_res_w[p], 128'(0));
    end
    reset = 1'b0;
    tick();

    // Single key-memory word
    km_word = 32'h00010203; km_req = 1'b1;
    tick(); km_req = 1'b0;
    for (int p = 0; p < 2; p++) chk("km_sboxw_T1", p, 128'(sboxw_w[p]), 128'(32'h00010203));
    tick();
    for (int p = 0; p < 2; p++) begin
      chk("km_ack_T2", p, 128'(km_ack_w[p]), 128'(1));
      chk("km_vec", p, 128'(km_res_w[p]), 128'(32'h637c777b));
    end
    tick();

    // Single block
    enc_block = 128'h00112233445566778899aabbccddeeff; enc_req = 1'b1;
    tick(); enc_req = 1'b0;
    repeat (3) tick();
    for (int p = 0; p < 2; p++) chk("enc_ack_T4", p, 128'(enc_ack_w[p]), 128'(0));
    tick();
    for (int p = 0; p < 2; p++) begin
      chk("enc_ack_T5", p, 128'(enc_ack_w[p]), 128'(1));
      chk("enc_vec", p, enc_res_w[p], 128'h638293c31bfc33f5c4eeacea4bc12816);
    end
    tick();

    // Both requests held: tie at T resolves to KM on both instances
    reset = 1'b1; tick(); reset = 1'b0; tick();
    km_word = 32'h0; enc_block = {$urandom, $urandom, $urandom, $urandom};
    km_req = 1'b1; enc_req = 1'b1;
    repeat (2) tick();
    for (int p = 0; p < 2; p++) chk("both_km_ack_T2", p, 128'(km_ack_w[p]), 128'(1));
    repeat (3) tick();
    chk("prio_no_enc_T5", 1, 128'(enc_ack_w[1]), 128'(0));
    repeat (2) tick();
    chk("rr_enc_ack_T7", 0, 128'(enc_ack_w[0]), 128'(1));
    repeat (2) tick();
    chk("rr_km_ack_T9", 0, 128'(km_ack_w[0]), 128'(1));
    repeat (10) tick();
    km_req = 1'b0; enc_req = 1'b0;
    repeat (8) tick();

    // KM request arriving during an ENC operation waits for it
    enc_block = {$urandom, $urandom, $urandom, $urandom}; enc_req = 1'b1;
    tick(); enc_req = 1'b0; kw = $urandom; km_word = kw; km_req = 1'b1;
    repeat (4) tick();
    for (int p = 0; p < 2; p++) begin
      chk("wait_enc_ack_T5", p, 128'(enc_ack_w[p]), 128'(1));
      chk("wait_km_ack_T5", p, 128'(km_ack_w[p]), 128'(0));
    end
    tick(); km_req = 1'b0;
    tick();
    for (int p = 0; p < 2; p++) begin
      chk("wait_km_ack_T7", p, 128'(km_ack_w[p]), 128'(1));
      chk("wait_km_result", p, 128'(km_res_w[p]), 128'(sub_word(kw)));
    end
    repeat (3) tick();

    // Reset in the middle of an ENC operation
    enc_block = {$urandom, $urandom, $urandom, $urandom}; enc_req = 1'b1;
    tick(); enc_req = 1'b0;
    tick(); reset = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      chk("abort_busy", p, 128'(busy_w[p]), 128'(0));
      chk("abort_sboxw", p, 128'(sboxw_w[p]), 128'(0));
      chk("abort_enc_result", p, enc_res_w[p], 128'(0));
    end
    reset = 1'b0;
    repeat (4) begin
      tick();
      for (int p = 0; p < 2; p++) chk("abort_no_ack", p, 128'(enc_ack_w[p]), 128'(0));
    end

    // Random traffic against the model
    repeat (500) begin
      km_req    = ($urandom_range(0, 9) < 6);
      enc_req   = ($urandom_range(0, 9) < 5);
      km_word   = $urandom;
      enc_block = {$urandom, $urandom, $urandom, $urandom};
      reset     = ($urandom_range(0, 63) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
